// File: rtl/stream_delay.sv
// Valid/ready stage that holds each beat back by a fixed or LFSR-drawn number of cycles.
// Payload is never registered; only valid_o/ready_o are gated by a small FSM and down-counter.
module stream_delay #(
   parameter int DATA_WIDTH   = 32,
   parameter bit STALL_RANDOM = 1'b0,
   parameter int FIXED_DELAY  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] payload_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] payload_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [1:0]            dbg_state_o
);

   // Handshake: a beat moves on a rising edge where valid and ready are both 1;
   // valid_o never depends on ready_i, and ready_o is only 1 while valid_o is 1.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_e;

   localparam int          FIX_W     = (FIXED_DELAY < 1) ? 1 : $clog2(FIXED_DELAY + 1);
   localparam int          CNT_W     = STALL_RANDOM ? 4 : FIX_W;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   assign payload_o = payload_i;

   if (!STALL_RANDOM && FIXED_DELAY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign valid_o        = valid_i;
      assign ready_o        = ready_i;
      assign dbg_state_o    = S_IDLE;
   end else begin : g_delay
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] dly;
      logic             draw;

      // A delay is drawn every time an idle stage sees a beat offered.
      assign draw = (state_q == S_IDLE) && valid_i;

      if (STALL_RANDOM) begin : g_rand
         logic [15:0] lfsr_q;
         logic        fb;
         assign fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
         assign dly = lfsr_q[3:0];
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               lfsr_q <= LFSR_SEED;
            end else if (draw) begin
               lfsr_q <= {fb, lfsr_q[15:1]};
            end
         end
      end else begin : g_fix
         assign dly = CNT_W'(FIXED_DELAY);
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         valid_o = 1'b0;
         ready_o = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  cnt_d = dly;
                  if (dly == '0) begin
                     // Zero delay: pass the beat straight through this cycle.
                     valid_o = 1'b1;
                     ready_o = ready_i;
                     if (!ready_i) state_d = S_READY;
                  end else if (dly == CNT_W'(1)) begin
                     state_d = S_READY;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!valid_i) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_d == CNT_W'(1)) state_d = S_READY;
               end
            end
            S_READY: begin
               valid_o = 1'b1;
               ready_o = ready_i;
               if (ready_i || !valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
         // The zero-delay path is combinational, so mask it while reset is held.
         if (rst_i) begin
            valid_o = 1'b0;
            ready_o = 1'b0;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      assign dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_stream_delay.sv
// Bench for stream_delay: one pass-through, four fixed-delay and one random-delay instance
// driven in turn, with a timing/payload scoreboard checked every cycle by a monitor.
module tb_stream_delay;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  vi  = '0;
   logic [5:0]  ri  = '0;
   logic [5:0]  vo;
   logic [5:0]  ro;
   logic [31:0] pay_i [6];
   logic [31:0] pay_o [6];
   logic [1:0]  dbg_unused [6];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cur      = -1;

   // Scoreboard: expected payload and the edge after which valid_o must be high.
   logic [31:0] exp_q[$];
   int          rise_q[$];
   logic [15:0] lfsr_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b0), .FIXED_DELAY(0)) u_pt (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[0]), .valid_i(vi[0]), .ready_o(ro[0]),
      .payload_o(pay_o[0]), .valid_o(vo[0]), .ready_i(ri[0]), .dbg_state_o(dbg_unused[0]));
   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b0), .FIXED_DELAY(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[1]), .valid_i(vi[1]), .ready_o(ro[1]),
      .payload_o(pay_o[1]), .valid_o(vo[1]), .ready_i(ri[1]), .dbg_state_o(dbg_unused[1]));
   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b0), .FIXED_DELAY(2)) u_d2 (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[2]), .valid_i(vi[2]), .ready_o(ro[2]),
      .payload_o(pay_o[2]), .valid_o(vo[2]), .ready_i(ri[2]), .dbg_state_o(dbg_unused[2]));
   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b0), .FIXED_DELAY(3)) u_d3 (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[3]), .valid_i(vi[3]), .ready_o(ro[3]),
      .payload_o(pay_o[3]), .valid_o(vo[3]), .ready_i(ri[3]), .dbg_state_o(dbg_unused[3]));
   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b0), .FIXED_DELAY(4)) u_d4 (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[4]), .valid_i(vi[4]), .ready_o(ro[4]),
      .payload_o(pay_o[4]), .valid_o(vo[4]), .ready_i(ri[4]), .dbg_state_o(dbg_unused[4]));
   stream_delay #(.DATA_WIDTH(32), .STALL_RANDOM(1'b1), .FIXED_DELAY(1)) u_rnd (
      .clk_i(clk), .rst_i(rst), .payload_i(pay_i[5]), .valid_i(vi[5]), .ready_o(ro[5]),
      .payload_o(pay_o[5]), .valid_o(vo[5]), .ready_i(ri[5]), .dbg_state_o(dbg_unused[5]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   // Called just after edge e. A beat offered then must show valid_o after edge e+d,
   // and with ready low for `stall` valid cycles it hands off at edge e+d+stall+1.
   task automatic send_beat(input int k, input logic [31:0] data, input int d, input int stall);
      pay_i[k] = data;
      vi[k]    = 1'b1;
      ri[k]    = (stall == 0);
      exp_q.push_back(data);
      rise_q.push_back(cyc + d);
      repeat (d + stall) @(posedge clk);
      #1;
      ri[k] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every instance against the scoreboard between edges.
   always @(negedge clk) begin
      bit ev;
      check("pt_valid", 32'(vo[0]), 32'(vi[0]));
      check("pt_ready", 32'(ro[0]), 32'(ri[0]));
      check("pt_payload", pay_o[0], pay_i[0]);
      for (int k = 1; k < 6; k++) begin
         ev = (k == cur) && (exp_q.size() > 0) && (cyc >= rise_q[0]);
         check($sformatf("valid_o[%0d]", k), 32'(vo[k]), 32'(ev));
         check($sformatf("ready_o[%0d]", k), 32'(ro[k]), 32'(ev && ri[k]));
         if (ev) begin
            check($sformatf("payload_o[%0d]", k), pay_o[k], exp_q[0]);
            if (ri[k]) begin
               void'(exp_q.pop_front());
               void'(rise_q.pop_front());
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 6; k++) pay_i[k] = '0;
      idle(3);
      rst = 1'b0;
      idle(2);

      // Pass-through: zero latency on every signal.
      cur      = 0;
      pay_i[0] = 32'hDEADBEEF;
      vi[0]    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ri[0] = i[0];
         #1;
         check("pt_comb_ready", 32'(ro[0]), 32'(ri[0]));
         idle(1);
      end
      for (int i = 0; i < 12; i++) begin
         pay_i[0] = $urandom;
         vi[0]    = 1'($urandom_range(0, 1));
         ri[0]    = 1'($urandom_range(0, 1));
         #1;
         check("pt_comb_payload", pay_o[0], pay_i[0]);
         idle(1);
      end
      vi[0] = 1'b0;
      ri[0] = 1'b0;
      idle(2);

      // Fixed delay 3: single beat, then valid_o must drop.
      cur = 3;
      send_beat(3, 32'h12345678, 3, 0);
      vi[3] = 1'b0;
      idle(3);
      for (int i = 0; i < 4; i++) send_beat(3, $urandom, 3, $urandom_range(0, 3));
      vi[3] = 1'b0;
      idle(3);
      check("drain_d3", 32'(exp_q.size()), 32'd0);

      // Fixed delay 1: back-to-back beats, then a 4-cycle downstream stall.
      cur = 1;
      for (int i = 0; i < 3; i++) send_beat(1, $urandom, 1, 0);
      send_beat(1, 32'h0BADCAFE, 1, 4);
      vi[1] = 1'b0;
      idle(3);
      check("drain_d1", 32'(exp_q.size()), 32'd0);

      // Fixed delay 2: five streamed beats, 3 cycles each.
      cur = 2;
      for (int i = 0; i < 5; i++) send_beat(2, i, 2, 0);
      vi[2] = 1'b0;
      idle(3);
      check("drain_d2", 32'(exp_q.size()), 32'd0);

      // Random delay: model the LFSR draw per beat, with gaps and occasional stalls.
      cur    = 5;
      lfsr_m = 16'hACE1;
      for (int i = 0; i < 100; i++) begin
         int d;
         if ($urandom_range(0, 4) == 0) begin
            vi[5] = 1'b0;
            idle(1);
         end
         d      = int'(lfsr_m[3:0]);
         lfsr_m = lfsr_next(lfsr_m);
         send_beat(5, $urandom, d, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      vi[5] = 1'b0;
      idle(3);
      check("drain_rnd", 32'(exp_q.size()), 32'd0);

      // Fixed delay 4: retraction in WAIT, then reset in WAIT and in READY.
      cur      = 4;
      pay_i[4] = 32'hBAD0BAD0;
      vi[4]    = 1'b1;
      ri[4]    = 1'b1;
      idle(2);
      vi[4] = 1'b0;
      idle(1);
      send_beat(4, 32'h0000A5A5, 4, 0);

      pay_i[4] = 32'hCAFEF00D;
      vi[4]    = 1'b1;
      idle(2);
      #2 rst = 1'b1;
      #1;
      check("rst_wait_valid", 32'(vo[4]), 32'd0);
      check("rst_wait_ready", 32'(ro[4]), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      send_beat(4, 32'hCAFEF00D, 4, 0);

      pay_i[4] = 32'h600DD00D;
      vi[4]    = 1'b1;
      ri[4]    = 1'b0;
      exp_q.push_back(32'h600DD00D);
      rise_q.push_back(cyc + 4);
      idle(5);
      #2;
      rst   = 1'b1;
      ri[4] = 1'b1;
      exp_q.delete();
      rise_q.delete();
      #1;
      check("rst_ready_valid", 32'(vo[4]), 32'd0);
      check("rst_ready_ready", 32'(ro[4]), 32'd0);
      check("rst_ready_payload", pay_o[4], 32'h600DD00D);
      @(posedge clk);
      #1 rst = 1'b0;
      vi[4] = 1'b0;
      idle(3);
      check("drain_d4", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
